// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: triangular sweep sequencer for an n-bit up/down counter.
// Ports: clock, reset (sync, active-high); start/abort controls; lo/hi/div/sweeps
//   configuration (latched on accepted start); q, dir, busy, done, err status.
module counter_sweep_ctrl #(
    parameter int N     = 3,
    parameter int DIV_W = 4,
    parameter int DWELL = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [N-1:0]     lo,
    input  logic [N-1:0]     hi,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       sweeps,
    output logic [N-1:0]     q,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int DW_W = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_TOP,
        DOWN,
        HOLD_BOT
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]     lo_l;
    logic [N-1:0]     hi_l;
    logic [DIV_W-1:0] div_l;
    logic [3:0]       sweeps_l;
    logic [DIV_W-1:0] pc;
    logic [DW_W-1:0]  dwell;
    logic [3:0]       sweep_cnt;
    logic [3:0]       sweep_inc;
    logic [N-1:0]     q_inc;
    logic [N-1:0]     q_dec;

    logic start_ok;
    logic accept;
    logic reject;
    logic tick;
    logic top_hit;
    logic bot_hit;
    logic dwell_end;
    logic last_sweep;

    // abort in IDLE swallows a same-cycle start
    assign start_ok   = (state == IDLE) && start && !abort;
    assign accept     = start_ok && (lo < hi);
    assign reject     = start_ok && !(lo < hi);
    assign tick       = busy && (pc == div_l);
    assign q_inc      = q + 1'b1;
    assign q_dec      = q - 1'b1;
    assign top_hit    = (q_inc == hi_l);
    assign bot_hit    = (q_dec == lo_l);
    assign dwell_end  = (dwell == DWELL_LAST);
    assign sweep_inc  = sweep_cnt + 4'd1;
    assign last_sweep = (sweeps_l != 4'd0) && (sweep_inc == sweeps_l);

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) state_next = UP;
                end
                UP: begin
                    if (tick && top_hit)
                        state_next = (DWELL == 0) ? DOWN : HOLD_TOP;
                end
                HOLD_TOP: begin
                    if (tick && dwell_end) state_next = DOWN;
                end
                DOWN: begin
                    if (tick && bot_hit) begin
                        if (last_sweep)
                            state_next = IDLE;
                        else
                            state_next = (DWELL == 0) ? UP : HOLD_BOT;
                    end
                end
                HOLD_BOT: begin
                    if (tick && dwell_end) state_next = UP;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // output decode
    always_comb begin
        busy = (state != IDLE);
    end

    // datapath: counter, direction, prescaler, dwell and sweep counters
    always_ff @(posedge clock) begin
        if (reset) begin
            q         <= '0;
            dir       <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            lo_l      <= '0;
            hi_l      <= '0;
            div_l     <= '0;
            sweeps_l  <= '0;
            pc        <= '0;
            dwell     <= '0;
            sweep_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (reject) err <= 1'b1;
            if (accept) begin
                lo_l      <= lo;
                hi_l      <= hi;
                div_l     <= div;
                sweeps_l  <= sweeps;
                err       <= 1'b0;
                q         <= lo;
                dir       <= 1'b1;
                sweep_cnt <= '0;
                dwell     <= '0;
            end else if (!abort && tick) begin
                unique case (state)
                    UP: begin
                        q <= q_inc;
                        if (top_hit && DWELL == 0) dir <= 1'b0;
                    end
                    HOLD_TOP: begin
                        if (dwell_end) begin
                            dwell <= '0;
                            dir   <= 1'b0;
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                    DOWN: begin
                        q <= q_dec;
                        if (bot_hit) begin
                            sweep_cnt <= sweep_inc;
                            if (last_sweep)
                                done <= 1'b1;
                            else if (DWELL == 0)
                                dir <= 1'b1;
                        end
                    end
                    HOLD_BOT: begin
                        if (dwell_end) begin
                            dwell <= '0;
                            dir   <= 1'b1;
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // prescaler restarts on every state entry so each phase gets full periods
            if (accept || (state_next != state))
                pc <= '0;
            else if (tick)
                pc <= '0;
            else if (busy)
                pc <= pc + 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb_counter_sweep_ctrl: two instances (DWELL=2 and DWELL=0) on shared stimulus,
// checked every cycle against a trajectory-queue model, plus literal spot checks.
module tb_counter_sweep_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] lo;
    logic [2:0] hi;
    logic [3:0] div;
    logic [3:0] sweeps;

    logic [2:0] q0, q1;
    logic       dir0, dir1, busy0, busy1, done0, done1, err0, err1;

    int checks = 0;
    int errors = 0;

    counter_sweep_ctrl #(.N(3), .DIV_W(4), .DWELL(2)) dut0 (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .div(div), .sweeps(sweeps),
        .q(q0), .dir(dir0), .busy(busy0), .done(done0), .err(err0)
    );

    counter_sweep_ctrl #(.N(3), .DIV_W(4), .DWELL(0)) dut1 (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .div(div), .sweeps(sweeps),
        .q(q1), .dir(dir1), .busy(busy1), .done(done1), .err(err1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An accepted start expands into the full per-cycle trajectory of
    // (q, dir, done); each cycle pops one entry. Continuous runs are refilled.
    typedef struct packed {
        logic [2:0] q;
        logic       dir;
        logic       done;
    } ent_t;

    ent_t fifo [2][1024];
    int   head [2];
    int   cnt  [2];
    bit   active [2];
    int   m_lo [2], m_hi [2], m_div [2], m_sw [2], m_idx [2];
    int   dw   [2] = '{2, 0};
    int   cq [2], cdir [2], cbusy [2], cdone [2], cerr [2];
    bit   mvalid = 1'b0;

    task automatic push(input int m, input int v, input int d, input int dn);
        ent_t e;
        e.q    = 3'(v);
        e.dir  = d[0];
        e.done = dn[0];
        fifo[m][(head[m] + cnt[m]) % 1024] = e;
        cnt[m]++;
    endtask

    task automatic add_sweep(input int m);
        int per;
        per = m_div[m] + 1;
        for (int v = m_lo[m]; v < m_hi[m]; v++)
            for (int k = 0; k < per; k++) push(m, v, 1, 0);
        for (int k = 0; k < dw[m] * per; k++) push(m, m_hi[m], 1, 0);
        for (int v = m_hi[m]; v > m_lo[m]; v--)
            for (int k = 0; k < per; k++) push(m, v, 0, 0);
        m_idx[m]++;
        if (m_sw[m] != 0 && m_idx[m] == m_sw[m]) begin
            push(m, m_lo[m], 0, 1);
            active[m] = 1'b0;
        end else begin
            for (int k = 0; k < dw[m] * per; k++) push(m, m_lo[m], 0, 0);
        end
    endtask

    task automatic pop(input int m);
        ent_t e;
        if (active[m] && cnt[m] < 2) add_sweep(m);
        if (cnt[m] == 0) begin
            errors++;
            $display("FAIL model_underflow dut%0d: got 0 entries, expected >0", m);
            cbusy[m] = 0;
        end else begin
            e        = fifo[m][head[m]];
            head[m]  = (head[m] + 1) % 1024;
            cnt[m]--;
            cq[m]    = int'(e.q);
            cdir[m]  = int'(e.dir);
            cdone[m] = int'(e.done);
            cbusy[m] = e.done ? 0 : 1;
        end
    endtask

    task automatic model_step(input int m);
        if (reset) begin
            cq[m] = 0; cdir[m] = 1; cbusy[m] = 0; cdone[m] = 0; cerr[m] = 0;
            cnt[m] = 0; head[m] = 0; active[m] = 1'b0;
            mvalid = 1'b1;
        end else if (abort) begin
            if (cbusy[m] != 0) begin
                cnt[m] = 0; head[m] = 0; active[m] = 1'b0; cbusy[m] = 0;
            end
            cdone[m] = 0;
        end else if (start && cbusy[m] == 0) begin
            cdone[m] = 0;
            if (lo >= hi) begin
                cerr[m] = 1;
            end else begin
                cerr[m]   = 0;
                m_lo[m]   = int'(lo);
                m_hi[m]   = int'(hi);
                m_div[m]  = int'(div);
                m_sw[m]   = int'(sweeps);
                m_idx[m]  = 0;
                cnt[m]    = 0;
                head[m]   = 0;
                active[m] = 1'b1;
                add_sweep(m);
                pop(m);
            end
        end else if (cbusy[m] != 0) begin
            pop(m);
        end else begin
            cdone[m] = 0;
        end
    endtask

    initial forever begin
        @(posedge clock);
        for (int m = 0; m < 2; m++) model_step(m);
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clock);
        if (mvalid) begin
            cmp("dut0_q",    int'(q0),    cq[0]);
            cmp("dut0_dir",  int'(dir0),  cdir[0]);
            cmp("dut0_busy", int'(busy0), cbusy[0]);
            cmp("dut0_done", int'(done0), cdone[0]);
            cmp("dut0_err",  int'(err0),  cerr[0]);
            cmp("dut1_q",    int'(q1),    cq[1]);
            cmp("dut1_dir",  int'(dir1),  cdir[1]);
            cmp("dut1_busy", int'(busy1), cbusy[1]);
            cmp("dut1_done", int'(done1), cdone[1]);
            cmp("dut1_err",  int'(err1),  cerr[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while ((busy0 || busy1) && t < limit) begin
            cyc();
            t++;
        end
        if (busy0 || busy1) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy after %0d cycles, expected idle", limit);
        end
    endtask

    task automatic go(input int l, input int h, input int d, input int s);
        lo     = 3'(l);
        hi     = 3'(h);
        div    = 4'(d);
        sweeps = 4'(s);
        start  = 1'b1;
        cyc();
        start  = 1'b0;
    endtask

    int e1q    [5] = '{1, 2, 3, 2, 1};
    int e1dir  [5] = '{1, 1, 0, 0, 0};
    int e1busy [5] = '{1, 1, 1, 1, 0};
    int e1done [5] = '{0, 0, 0, 0, 1};

    initial begin
        int nb, nd, nh, t, maxq;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; div = '0; sweeps = '0;
        cyc();
        cmp("rst_q",    int'(q0),    0);
        cmp("rst_dir",  int'(dir0),  1);
        cmp("rst_busy", int'(busy0), 0);
        cmp("rst_err",  int'(err1),  0);
        cyc();
        reset = 1'b0;
        cyc();

        // 1: DWELL=0 single sweep, every-cycle ticks
        go(1, 3, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cmp("t1_q",       int'(q1),    e1q[i]);
            cmp("t1_dir",     int'(dir1),  e1dir[i]);
            cmp("t1_busy",    int'(busy1), e1busy[i]);
            cmp("t1_done",    int'(done1), e1done[i]);
            cmp("t1_model_q", cq[1],       e1q[i]);
            cyc();
        end
        cmp("t1_done_clear", int'(done1), 0);
        wait_idle(50);
        cyc();

        // 2: DWELL=2, div=1
        go(0, 2, 1, 1);
        nb = 0; nd = 0; nh = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy0) nb++;
            if (done0) nd++;
            if (busy0 && q0 == 3'd2 && dir0) nh++;
            cyc();
        end
        cmp("t2_busy_cycles", nb, 12);
        cmp("t2_done_pulses", nd, 1);
        cmp("t2_top_hold",    nh, 4);
        cmp("t2_final_q",     int'(q0), 0);

        // 3: rejected start then accepted start
        go(5, 5, 0, 1);
        cmp("t3_err0",  int'(err0),  1);
        cmp("t3_err1",  int'(err1),  1);
        cmp("t3_busy0", int'(busy0), 0);
        cmp("t3_q0",    int'(q0),    0);
        go(2, 4, 0, 1);
        cmp("t3_err_clr", int'(err0),  0);
        cmp("t3_q_lo",    int'(q0),    2);
        cmp("t3_busy",    int'(busy0), 1);
        wait_idle(50);
        cyc();

        // 4: continuous full range, then abort at q=5
        go(0, 7, 0, 0);
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            if (done0 || done1) nd++;
            cyc();
        end
        cmp("t4_no_done", nd, 0);
        t = 0;
        while (q1 != 3'd5 && t < 40) begin
            cyc();
            t++;
        end
        cmp("t4_reach5", int'(q1), 5);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cmp("t4_abort_q",    int'(q1),    5);
        cmp("t4_abort_busy", int'(busy1), 0);
        cmp("t4_abort_done", int'(done1), 0);
        cyc();

        // 5: reset mid-sweep, then start+abort in IDLE
        go(0, 7, 0, 0);
        t = 0;
        while (!(q1 == 3'd3 && !dir1) && t < 60) begin
            cyc();
            t++;
        end
        cmp("t5_reach3_down", int'(q1), 3);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cmp("t5_rst_q",    int'(q1),    0);
        cmp("t5_rst_dir",  int'(dir1),  1);
        cmp("t5_rst_busy", int'(busy1), 0);
        cmp("t5_rst_err",  int'(err1),  0);
        abort = 1'b1;
        go(1, 3, 0, 1);
        abort = 1'b0;
        cmp("t5_sa_busy0", int'(busy0), 0);
        cmp("t5_sa_busy1", int'(busy1), 0);
        cmp("t5_sa_q1",    int'(q1),    0);
        cyc();

        // 6: re-start and limit changes while busy are ignored
        go(1, 4, 1, 2);
        repeat (5) cyc();
        go(0, 7, 0, 0);
        maxq = 0;
        t = 0;
        while (busy1 && t < 200) begin
            if (int'(q1) > maxq) maxq = int'(q1);
            cyc();
            t++;
        end
        cmp("t6_max_q",  maxq,        4);
        cmp("t6_final",  int'(q1),    1);
        cmp("t6_done",   int'(done1), 1);
        wait_idle(200);
        cyc();

        // random phase
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 299) == 0);
            abort  = ($urandom_range(0, 79) == 0);
            start  = ($urandom_range(0, 11) == 0);
            lo     = 3'($urandom_range(0, 7));
            hi     = 3'($urandom_range(0, 7));
            div    = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 2))
                                                : 4'($urandom_range(0, 15));
            sweeps = 4'($urandom_range(0, 3));
            cyc();
        end
        reset = 1'b0; abort = 1'b0; start = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
